rs_decode_sequencer: RTL and testbench
======================================

Name: rs_decode_sequencer

Overview:
Top-level frame scheduler for the RS(15,11) GF(16) decoder. It accepts one codeword at a time and sequences three stages: syndrome calculation, the Euclid key-equation solver, and Chien search/Forney correction. It bypasses the solver when all syndromes are zero, guards the solver with a timeout, and presents a per-frame status through a valid/ready output handshake. It also keeps saturating frame-statistics counters.

Parameters:
EUC_TIMEOUT, 32, maximum cycles from euc_start to the solver's finished pulse before the frame is declared failed (legal range 2..255).
CNT_W, 16, width of each statistics counter.

Ports:
CLK  input  1  system clock; all logic on rising edge
RESET  input  1  synchronous, active-high reset
in_valid  input  1  a buffered codeword is ready for decoding
in_ready  output  1  sequencer can accept a frame (high only in IDLE)
syn_start  output  1  one-cycle pulse that starts the syndrome unit
syn_done  input  1  one-cycle pulse; syndromes S_0..S_3 are valid
syn_zero  input  1  all four syndromes are zero; sampled with syn_done
euc_start  output  1  one-cycle pulse that starts the Euclid solver
euc_done  input  1  Euclid finished pulse; LAMBDA/OMEGA outputs are held
chien_start  output  1  one-cycle pulse that starts Chien/Forney
chien_done  input  1  one-cycle pulse; correction complete
chien_fail  input  1  root count does not match deg(LAMBDA); sampled with chien_done
out_valid  output  1  frame result available
out_ready  input  1  downstream accepts the result
out_status  output  2  00 CLEAN, 01 CORRECTED, 10 FAIL, 11 reserved (never driven)
busy  output  1  high in any state other than IDLE
cnt_clean  output  CNT_W  saturating count of CLEAN frames
cnt_corr  output  CNT_W  saturating count of CORRECTED frames
cnt_fail  output  CNT_W  saturating count of FAIL frames

Behaviour:
- States: IDLE, SYN, EUC, CHIEN, OUT. The state register and all outputs are registered.
- Reset values: state=IDLE; in_ready=1; all start pulses=0; out_valid=0; out_status=00; busy=0; timeout counter=0; all cnt_*=0. Reset applied in any state aborts the frame immediately; no partial result or counter update occurs.
- IDLE: in_ready=1. On in_valid=1, go to SYN and assert syn_start in the next cycle only (acceptance at cycle T gives syn_start at T+1).
- SYN: wait for syn_done.
  - syn_done with syn_zero=1: go to OUT with status CLEAN. No euc_start is issued.
  - syn_done with syn_zero=0: go to EUC, pulse euc_start in the next cycle, clear the timeout counter.
- EUC: the timeout counter increments every cycle.
  - euc_done: go to CHIEN and pulse chien_start in the next cycle.
  - Counter reaching EUC_TIMEOUT-1 without euc_done: go to OUT with status FAIL.
  - euc_done in the same cycle as the timeout: euc_done wins.
- CHIEN: wait for chien_done.
  - chien_fail=1: go to OUT with status FAIL.
  - chien_fail=0: go to OUT with status CORRECTED.
  - There is no timeout in this state; the Chien stage is fixed-length (15 cycles).
- OUT: out_valid=1 and out_status is stable until out_ready=1.
  - On the handshake cycle, the matching counter increments (saturating at all-ones) and the state returns to IDLE.
  - out_valid and in_ready are never high together, so the minimum gap between frames is one IDLE cycle.
- Done pulses (syn_done, euc_done, chien_done) that arrive in a state other than their own are ignored. This covers stray solver finished pulses after a timeout.
- Only one start pulse is ever high in a given cycle, and each start pulse lasts exactly one cycle.
- Minimum latency from acceptance to out_valid, bypass path: acceptance T, syn_start T+1, syn_done at earliest T+2, out_valid T+3.

Decomposition:
- Shared package rs_pkg holds:
  - GF width 4, N=15, K=11, T=2;
  - status encodings STAT_CLEAN/STAT_CORR/STAT_FAIL;
  - the sequencer state enumeration.
- Sub-module sat_counter (parameter width; inputs inc and synchronous clear; output count, saturating) is instantiated three times.
- The timeout counter stays inline.

Test Plan:
- Zero-syndrome bypass: in_valid at cycle 0, syn_done+syn_zero at cycle 3 -> out_valid at cycle 4 with status 00; euc_start never asserted; after out_ready, cnt_clean=1.
- Correctable frame: syn_done (syn_zero=0), euc_done 20 cycles after euc_start, chien_done with chien_fail=0 -> status 01; cnt_corr=1; exactly one pulse each of syn_start, euc_start, chien_start.
- Solver timeout: EUC_TIMEOUT=32, no euc_done -> OUT with status 10 exactly 32 cycles after euc_start; a late euc_done in OUT is ignored; cnt_fail=1.
- Boundary race: euc_done in the same cycle the timeout fires -> CHIEN entered, status follows chien_fail; no FAIL recorded.
- Backpressure and saturation: hold out_ready=0 for 50 cycles -> out_valid and out_status stable, in_ready=0 throughout; with CNT_W=2, 5 CLEAN frames -> cnt_clean=3.
- Reset mid-operation: RESET high for one cycle while in EUC -> next cycle IDLE, in_ready=1, no start pulses, counters 0; a fresh frame then decodes normally.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared constants for the RS(15,11) GF(16) decoder: code geometry, frame
// status encodings and the frame sequencer state codes.
package rs_pkg;

    localparam int GF_W = 4;
    localparam int RS_N = 15;
    localparam int RS_K = 11;
    localparam int RS_T = 2;

    localparam logic [1:0] STAT_CLEAN = 2'b00;
    localparam logic [1:0] STAT_CORR  = 2'b01;
    localparam logic [1:0] STAT_FAIL  = 2'b10;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE  = 3'd0;
    localparam seq_state_t ST_SYN   = 3'd1;
    localparam seq_state_t ST_EUC   = 3'd2;
    localparam seq_state_t ST_CHIEN = 3'd3;
    localparam seq_state_t ST_OUT   = 3'd4;

    // Status of a frame that reached the Chien/Forney stage.
    function automatic logic [1:0] chien_status(input logic fail);
        return fail ? STAT_FAIL : STAT_CORR;
    endfunction

endpackage

// File: rtl/rs_decode_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // NOTE: clocked state is written with non-blocking assignments only, so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/rs_decode_sequencer.sv
// Frame scheduler for the RS(15,11) decoder: syndrome -> Euclid -> Chien/Forney,
// with zero-syndrome bypass, solver timeout and a valid/ready status output.
module rs_decode_sequencer
    import rs_pkg::*;
#(
    parameter int EUC_TIMEOUT = 32,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             syn_start,
    input  logic             syn_done,
    input  logic             syn_zero,
    output logic             euc_start,
    input  logic             euc_done,
    output logic             chien_start,
    input  logic             chien_done,
    input  logic             chien_fail,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_status,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_clean,
    output logic [CNT_W-1:0] cnt_corr,
    output logic [CNT_W-1:0] cnt_fail
);

    localparam logic [7:0] TO_LAST = 8'(EUC_TIMEOUT - 1);
    localparam logic [7:0] TO_ONE  = 8'd1;

    seq_state_t state;
    logic [7:0] to_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            in_ready    <= 1'b1;
            syn_start   <= 1'b0;
            euc_start   <= 1'b0;
            chien_start <= 1'b0;
            out_valid   <= 1'b0;
            out_status  <= STAT_CLEAN;
            busy        <= 1'b0;
            to_cnt      <= '0;
        end else begin
            // Start pulses are one cycle wide unless re-asserted below.
            syn_start   <= 1'b0;
            euc_start   <= 1'b0;
            chien_start <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state     <= ST_SYN;
                        syn_start <= 1'b1;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                ST_SYN: begin
                    if (syn_done) begin
                        if (syn_zero) begin
                            state      <= ST_OUT;
                            out_valid  <= 1'b1;
                            out_status <= STAT_CLEAN;
                        end else begin
                            state     <= ST_EUC;
                            euc_start <= 1'b1;
                            to_cnt    <= '0;
                        end
                    end
                end

                ST_EUC: begin
                    // A finished pulse in the timeout cycle still counts as success.
                    if (euc_done) begin
                        state       <= ST_CHIEN;
                        chien_start <= 1'b1;
                    end else if (to_cnt == TO_LAST) begin
                        state      <= ST_OUT;
                        out_valid  <= 1'b1;
                        out_status <= STAT_FAIL;
                    end else begin
                        to_cnt <= to_cnt + TO_ONE;
                    end
                end

                ST_CHIEN: begin
                    if (chien_done) begin
                        state      <= ST_OUT;
                        out_valid  <= 1'b1;
                        out_status <= chien_status(chien_fail);
                    end
                end

                ST_OUT: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Statistics advance on the result handshake only.
    logic handshake;
    assign handshake = out_valid && out_ready && (state == ST_OUT);

    sat_counter #(.WIDTH(CNT_W)) u_cnt_clean (
        .clk   (CLK),
        .clear (RESET),
        .inc   (handshake && (out_status == STAT_CLEAN)),
        .count (cnt_clean)
    );

    sat_counter #(.WIDTH(CNT_W)) u_cnt_corr (
        .clk   (CLK),
        .clear (RESET),
        .inc   (handshake && (out_status == STAT_CORR)),
        .count (cnt_corr)
    );

    sat_counter #(.WIDTH(CNT_W)) u_cnt_fail (
        .clk   (CLK),
        .clear (RESET),
        .inc   (handshake && (out_status == STAT_FAIL)),
        .count (cnt_fail)
    );

endmodule

// File: tb/tb_rs_decode_sequencer.sv
// Self-checking bench for rs_decode_sequencer: emulates the three decoder
// stages, scoreboards frame status and models the saturating statistics.
module tb_rs_decode_sequencer;
    import rs_pkg::*;

    localparam int EUC_TO = 32;
    localparam int CW     = 2;
    localparam int CMAX   = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          syn_start;
    logic          syn_done = 1'b0;
    logic          syn_zero = 1'b0;
    logic          euc_start;
    logic          euc_done = 1'b0;
    logic          chien_start;
    logic          chien_done = 1'b0;
    logic          chien_fail = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    out_status;
    logic          busy;
    logic [CW-1:0] cnt_clean;
    logic [CW-1:0] cnt_corr;
    logic [CW-1:0] cnt_fail;

    rs_decode_sequencer #(
        .EUC_TIMEOUT(EUC_TO),
        .CNT_W      (CW)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .syn_start  (syn_start),
        .syn_done   (syn_done),
        .syn_zero   (syn_zero),
        .euc_start  (euc_start),
        .euc_done   (euc_done),
        .chien_start(chien_start),
        .chien_done (chien_done),
        .chien_fail (chien_fail),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_status (out_status),
        .busy       (busy),
        .cnt_clean  (cnt_clean),
        .cnt_corr   (cnt_corr),
        .cnt_fail   (cnt_fail)
    );

    always #5 CLK = ~CLK;

    int         total = 0;
    int         bad   = 0;
    logic [1:0] exp_q[$];
    int         exp_cnt[3] = '{0, 0, 0};
    int         n_syn = 0, n_euc = 0, n_chien = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    always @(posedge CLK) begin
        if (syn_start)   n_syn++;
        if (euc_start)   n_euc++;
        if (chien_start) n_chien++;
    end

    // Scoreboard pop on the result handshake, plus per-cycle invariants.
    always @(negedge CLK) begin
        logic [1:0] e;
        if (!RESET && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("status", {30'd0, out_status}, {30'd0, e});
                if (int'(e) < 3 && exp_cnt[int'(e)] < CMAX) exp_cnt[int'(e)]++;
            end
        end
        if (!RESET && out_valid) check("in_ready_excl", {31'd0, in_ready}, 32'd0);
        if (syn_start || euc_start || chien_start)
            check("one_start", $countones({syn_start, euc_start, chien_start}), 32'd1);
    end

    task automatic check_counters(input string tag);
        check({tag, "_clean"}, {30'd0, cnt_clean}, exp_cnt[0]);
        check({tag, "_corr"},  {30'd0, cnt_corr},  exp_cnt[1]);
        check({tag, "_fail"},  {30'd0, cnt_fail},  exp_cnt[2]);
    endtask

    // euc_dly < 0 means the solver never finishes (timeout path).
    task automatic run_frame(input bit zero, input int euc_dly, input bit cfail,
                             input int hold, input logic [1:0] exp);
        int s0, e0, c0, k;
        s0 = n_syn; e0 = n_euc; c0 = n_chien;
        k = 0;
        while (!in_ready && k < 100) begin tick(); k++; end
        check("in_ready", {31'd0, in_ready}, 32'd1);

        in_valid = 1'b1;
        exp_q.push_back(exp);
        tick();
        in_valid = 1'b0;
        check("syn_start", {31'd0, syn_start}, 32'd1);
        check("busy", {31'd0, busy}, 32'd1);
        check("no_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        syn_done = 1'b1;
        syn_zero = zero;
        tick();
        syn_done = 1'b0;
        syn_zero = 1'b0;

        if (zero) begin
            check("bypass_lat", {31'd0, out_valid}, 32'd1);
        end else begin
            check("euc_start", {31'd0, euc_start}, 32'd1);
            if (euc_dly < 0) begin
                repeat (EUC_TO - 1) tick();
                check("pre_timeout", {31'd0, out_valid}, 32'd0);
                tick();
                check("timeout_lat", {31'd0, out_valid}, 32'd1);
                euc_done = 1'b1;
                tick();
                euc_done = 1'b0;
                check("late_euc_chien", {31'd0, chien_start}, 32'd0);
                check("late_euc_valid", {31'd0, out_valid}, 32'd1);
            end else begin
                repeat (euc_dly) tick();
                euc_done = 1'b1;
                tick();
                euc_done = 1'b0;
                check("chien_start", {31'd0, chien_start}, 32'd1);
                check("chien_no_out", {31'd0, out_valid}, 32'd0);
                repeat (14) tick();
                chien_done = 1'b1;
                chien_fail = cfail;
                tick();
                chien_done = 1'b0;
                chien_fail = 1'b0;
            end
        end

        k = 0;
        while (!out_valid && k < 50) begin tick(); k++; end
        check("out_valid", {31'd0, out_valid}, 32'd1);
        repeat (hold) begin
            tick();
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_status", {30'd0, out_status}, {30'd0, exp});
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_hs_valid", {31'd0, out_valid}, 32'd0);
        check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_hs_busy", {31'd0, busy}, 32'd0);
        check_counters("cnt");
        check("n_syn", n_syn - s0, 32'd1);
        check("n_euc", n_euc - e0, zero ? 32'd0 : 32'd1);
        check("n_chien", n_chien - c0, (!zero && euc_dly >= 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_status", {30'd0, out_status}, 32'd0);
        check("rst_starts", {29'd0, syn_start, euc_start, chien_start}, 32'd0);
        check_counters("rst_cnt");
        RESET = 1'b0;
        tick();

        run_frame(1'b1, 0,  1'b0, 0,  STAT_CLEAN);   // zero-syndrome bypass
        run_frame(1'b0, 20, 1'b0, 1,  STAT_CORR);    // correctable frame
        run_frame(1'b0, -1, 1'b0, 2,  STAT_FAIL);    // solver timeout, late euc_done
        run_frame(1'b0, 31, 1'b0, 0,  STAT_CORR);    // euc_done on the timeout cycle
        run_frame(1'b1, 0,  1'b0, 50, STAT_CLEAN);   // long backpressure
        run_frame(1'b0, 5,  1'b1, 3,  STAT_FAIL);    // chien_fail

        // Abort a frame while the solver is running.
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        syn_done = 1'b1;
        tick();
        syn_done = 1'b0;
        repeat (5) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        exp_cnt = '{0, 0, 0};
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_starts", {29'd0, syn_start, euc_start, chien_start}, 32'd0);
        check_counters("abort_cnt");
        tick();
        check("abort_idle_starts", {29'd0, syn_start, euc_start, chien_start}, 32'd0);

        run_frame(1'b0, 10, 1'b0, 1, STAT_CORR);     // fresh frame after abort
        for (int i = 0; i < 5; i++) run_frame(1'b1, 0, 1'b0, 0, STAT_CLEAN);
        check("sat_clean", {30'd0, cnt_clean}, 32'd3);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
